moving_avg_filter: RTL
======================

Name: moving_avg_filter

Overview:
- Boxcar (moving-average) filter stage placed directly downstream of delay_line_var.
- Each sample strobe takes the new sample together with the sample from exactly N = 2**WINDOW_LOG2 strobes earlier, as produced by the delay line. It keeps a running window sum and outputs the rounded average.
- Used on ADC channels (gap voltage/current) to smooth samples before the control loop.

Parameters:
- DATA_WIDTH, 18, sample width, signed two's complement.
- WINDOW_LOG2, 6, log2 of window length N; the delay line upstream is programmed to delay N.
- SUM_WIDTH, DATA_WIDTH+WINDOW_LOG2, accumulator width (localparam, not overridable).

Ports:
- clock  in  1  system clock.
- aclr_n  in  1  asynchronous reset, active low.
- sclr  in  1  synchronous clear, priority over clock_ena.
- clock_ena  in  1  sample strobe; one sample per asserted cycle.
- data  in  DATA_WIDTH  new sample x[n], signed.
- data_dly  in  DATA_WIDTH  x[n-N] from the delay line; 0 until the delay line fills.
- sum  out  SUM_WIDTH  running window sum, signed.
- q  out  DATA_WIDTH  rounded average, signed.
- valid  out  1  one-cycle pulse: sum/q updated.
- full  out  1  window filled; q is a true N-sample average.

Behaviour:
- Reset (aclr_n=0, async) and sclr (sync): sum=0, q=0, valid=0, full=0, fill counter=0, state=EMPTY.
- States and transitions:
  - EMPTY: on the first strobe, go to FILL.
  - FILL: count strobes; on strobe number N (counter wraps to 0), go to FULL.
  - FULL: stay until aclr_n or sclr.
- full=1 exactly when state==FULL. It is registered, so it rises in the same cycle as the valid pulse of strobe N.
- On each strobe (clock_ena=1, sclr=0):
  - sum <= sum + sext(data) - sext(data_dly), computed at SUM_WIDTH.
  - Rounded average: q <= (sum_next + 2**(WINDOW_LOG2-1)) >>> WINDOW_LOG2, where sum_next is the newly computed sum.
  - valid <= 1 in the next cycle only. Latency from strobe to updated outputs is 1 clock.
- With no strobe: sum and q hold; valid=0.
- Rounding is round-half-up (toward +inf), computed at SUM_WIDTH+1 bits, then truncated to DATA_WIDTH.
  - No saturation is needed: |sum| ≤ N·2**(DATA_WIDTH-1), so the rounded result always fits DATA_WIDTH.
  - The bench must check the extremes.
- During FILL, q = sum/N, scaled as if the missing samples were 0. Consumers gate on full.
- data_dly contract:
  - Must be 0 for the first N strobes after clear, then equal x[n-N] on the same strobe.
  - sclr must be applied to the filter and the delay line together.
- Simultaneous sclr and clock_ena: sclr wins; the sample is discarded.
- Reset mid-FILL or mid-FULL: returns to EMPTY; the next strobe restarts the fill.
- Fill counter is WINDOW_LOG2 bits wide; its wrap-around defines the EMPTY/FILL→FULL transition. The counter is frozen in FULL.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package cnc_filter_pkg:
  - typedef for the filter state enum (EMPTY, FILL, FULL).
  - function round_shift(sum, shift) implementing round-half-up arithmetic shift.
  - localparam helper for SUM_WIDTH.
- Optional sub-module moving_avg_channel: wraps delay_line_var plus moving_avg_filter, tying delay = N and sharing sclr/clock_ena. This gives the upstream/downstream pair one instance per ADC channel.
- The filter itself stays a single module.

Test Plan:
- Bench setup: DATA_WIDTH=18, WINDOW_LOG2=2 (N=4), data_dly driven by a reference model of the delay line.
- Constant input: 100 on 6 strobes. Required response:
  - sum = 100, 200, 300, 400, 400, 400.
  - q = 25, 50, 75, 100, 100, 100.
  - full rises with the 4th valid pulse.
  - valid is one cycle after each strobe.
- Rounding: after fill, window {1,1,1,0} → sum=3, q=1. Window {-1,-1,-1,-1} → sum=-4, q=-1. Window {-1,-1,0,0} → sum=-2, q=0.
- Extremes:
  - Window of four 131071 → sum=524284, q=131071.
  - Window of four -131072 → sum=-524288, q=-131072.
  - Neither case wraps.
- Stall and step: strobes every 3rd cycle with a 0→1000 step. Required response:
  - q = 250, 500, 750, 1000 on successive valid pulses.
  - Outputs hold between strobes.
- Clears:
  - sclr asserted together with clock_ena mid-FILL: next cycle sum=0, q=0, full=0, valid=0.
  - aclr_n pulsed low mid-FULL: outputs zero immediately, asynchronously.
  - After either clear, the refill sequence repeats scenario 1 exactly.

Source files
------------

// File: rtl/cnc_filter_pkg.sv
// Shared types and arithmetic helpers for the CNC ADC filter chain.
// Rounding is done at a fixed wide width, then each filter truncates to its own width.
package cnc_filter_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } filter_state_t;

    // Wide enough for any realistic DATA_WIDTH + WINDOW_LOG2 combination.
    localparam int ROUND_WIDTH = 64;

    function automatic int sum_width(input int data_width, input int window_log2);
        return data_width + window_log2;
    endfunction

    // Round-half-up arithmetic right shift. One guard bit above the input
    // keeps the added half-LSB from overflowing.
    function automatic logic signed [ROUND_WIDTH:0] round_shift(
        input logic signed [ROUND_WIDTH-1:0] value,
        input int                            shift
    );
        logic signed [ROUND_WIDTH:0] ext;
        logic signed [ROUND_WIDTH:0] half;
        ext = {value[ROUND_WIDTH-1], value};
        if (shift <= 0) begin
            return ext;
        end
        half = 1;
        half = half <<< (shift - 1);
        ext  = ext + half;
        return ext >>> shift;
    endfunction

endpackage

// File: rtl/moving_avg_filter.sv
// Boxcar filter: keeps a running sum of the last 2**WINDOW_LOG2 samples and
// outputs the rounded average one clock after each sample strobe.
module moving_avg_filter
    import cnc_filter_pkg::*;
#(
    parameter  int DATA_WIDTH  = 18,
    parameter  int WINDOW_LOG2 = 6,
    localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, WINDOW_LOG2)
) (
    input  logic                         clock,
    input  logic                         aclr_n,
    input  logic                         sclr,
    input  logic                         clock_ena,
    input  logic signed [DATA_WIDTH-1:0] data,
    input  logic signed [DATA_WIDTH-1:0] data_dly,
    output logic signed [SUM_WIDTH-1:0]  sum,
    output logic signed [DATA_WIDTH-1:0] q,
    output logic                         valid,
    output logic                         full
);

    logic signed [SUM_WIDTH-1:0]  sum_reg;
    logic signed [SUM_WIDTH-1:0]  sum_next;
    logic signed [DATA_WIDTH-1:0] q_reg;
    logic signed [DATA_WIDTH-1:0] q_next;
    logic                         valid_reg;
    filter_state_t                state_reg;
    filter_state_t                state_next;
    logic [WINDOW_LOG2-1:0]       cnt_reg;
    logic [WINDOW_LOG2-1:0]       cnt_next;

    // The sample leaving the window is subtracted as the new one enters.
    always_comb begin
        sum_next = sum_reg
                 + {{WINDOW_LOG2{data[DATA_WIDTH-1]}}, data}
                 - {{WINDOW_LOG2{data_dly[DATA_WIDTH-1]}}, data_dly};
        q_next   = DATA_WIDTH'(round_shift(ROUND_WIDTH'(sum_next), WINDOW_LOG2));
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (clock_ena) begin
            unique case (state_reg)
                EMPTY: begin
                    cnt_next   = cnt_reg + WINDOW_LOG2'(1);
                    state_next = (cnt_next == '0) ? FULL : FILL;
                end
                FILL: begin
                    cnt_next = cnt_reg + WINDOW_LOG2'(1);
                    if (cnt_next == '0) begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    cnt_next = cnt_reg;
                end
                default: begin
                    state_next = EMPTY;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // sclr outranks clock_ena: a strobe coinciding with a clear is dropped.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            sum_reg   <= '0;
            q_reg     <= '0;
            valid_reg <= 1'b0;
            state_reg <= EMPTY;
            cnt_reg   <= '0;
        end else if (sclr) begin
            sum_reg   <= '0;
            q_reg     <= '0;
            valid_reg <= 1'b0;
            state_reg <= EMPTY;
            cnt_reg   <= '0;
        end else begin
            valid_reg <= clock_ena;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (clock_ena) begin
                sum_reg <= sum_next;
                q_reg   <= q_next;
            end
        end
    end

    assign sum   = sum_reg;
    assign q     = q_reg;
    assign valid = valid_reg;
    assign full  = (state_reg == FULL);

endmodule
